mfi_trace_emitter: RTL

Producer side of the MFI retirement trace. Dispatch supplies instruction records in program order, and functional units report completion by tag in any order. The block retires records strictly in program order and drives one MFI record per cycle with a monotonically increasing mfi_order, for consumption by the formal checks and trace monitors.

---
 rtl/mfi_trace_emitter_if.sv | 41 ++++
 rtl/mfi_trace_emitter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mfi_trace_emitter_if.sv
// Bundles the dispatch, completion and retirement-trace signals of the MFI trace emitter.
// The emitter uses the slave modport; the dispatch/execute side uses master.
interface mfi_trace_emitter_if #(
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
);
    localparam int TAG_W = $clog2(DEPTH);

    logic               flush;
    logic               disp_valid;
    logic               disp_ready;
    logic [TAG_W-1:0]   disp_tag;
    logic [31:0]        disp_insn;
    logic [4:0]         disp_src1_addr;
    logic [4:0]         disp_src2_addr;
    logic [4:0]         disp_dest_addr;
    logic               cmp_valid;
    logic [TAG_W-1:0]   cmp_tag;
    logic               mfi_valid;
    logic [ORDER_W-1:0] mfi_order;
    logic [31:0]        mfi_insn;
    logic [4:0]         mfi_src1_addr;
    logic [4:0]         mfi_src2_addr;
    logic [4:0]         mfi_dest_addr;
    logic [TAG_W:0]     occupancy;
    logic               err;

    modport master (
        output flush, disp_valid, disp_insn, disp_src1_addr, disp_src2_addr, disp_dest_addr,
        output cmp_valid, cmp_tag,
        input  disp_ready, disp_tag, mfi_valid, mfi_order, mfi_insn,
        input  mfi_src1_addr, mfi_src2_addr, mfi_dest_addr, occupancy, err
    );

    modport slave (
        input  flush, disp_valid, disp_insn, disp_src1_addr, disp_src2_addr, disp_dest_addr,
        input  cmp_valid, cmp_tag,
        output disp_ready, disp_tag, mfi_valid, mfi_order, mfi_insn,
        output mfi_src1_addr, mfi_src2_addr, mfi_dest_addr, occupancy, err
    );
endinterface

// File: rtl/mfi_trace_emitter.sv
// In-order retirement buffer that turns out-of-order completions into an MFI trace
// with one record per cycle and a monotonically increasing program-order index.
module mfi_trace_emitter #(
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    mfi_trace_emitter_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0]     PTR_ONE   = (TAG_W + 1)'(1);
    localparam logic [ORDER_W-1:0] ORDER_ONE = ORDER_W'(1);

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_done;
    logic [31:0]        ent_insn [DEPTH];
    logic [4:0]         ent_src1 [DEPTH];
    logic [4:0]         ent_src2 [DEPTH];
    logic [4:0]         ent_dest [DEPTH];

    logic [TAG_W:0]     head;
    logic [TAG_W:0]     tail;
    logic [TAG_W-1:0]   head_idx;
    logic [TAG_W-1:0]   tail_idx;
    logic [ORDER_W-1:0] order_count;

    logic               full;
    logic               disp_fire;
    logic               cmp_hit;
    logic               cmp_bad;
    logic               retire;

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full      = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign disp_fire = bus.disp_valid && !full && !bus.flush;

    // A completion is only legal for a live, not-yet-done entry that is not being allocated now.
    assign cmp_hit = bus.cmp_valid && !bus.flush
                     && ent_valid[bus.cmp_tag] && !ent_done[bus.cmp_tag]
                     && !(disp_fire && (bus.cmp_tag == tail_idx));
    assign cmp_bad = bus.cmp_valid && !bus.flush && !cmp_hit;

    assign retire = ent_valid[head_idx] && ent_done[head_idx] && !bus.flush;

    assign bus.disp_ready = !full;
    assign bus.disp_tag   = tail_idx;
    assign bus.occupancy  = tail - head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (bus.flush) begin
            ent_valid <= '0;
            ent_done  <= '0;
            tail      <= head;
        end else begin
            if (retire) begin
                ent_valid[head_idx] <= 1'b0;
                ent_done[head_idx]  <= 1'b0;
                head                <= head + PTR_ONE;
            end
            if (disp_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                tail                <= tail + PTR_ONE;
            end
            if (cmp_hit) begin
                ent_done[bus.cmp_tag] <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: an entry is only read once its valid bit is set.
    always_ff @(posedge clock) begin
        if (disp_fire) begin
            ent_insn[tail_idx] <= bus.disp_insn;
            ent_src1[tail_idx] <= bus.disp_src1_addr;
            ent_src2[tail_idx] <= bus.disp_src2_addr;
            ent_dest[tail_idx] <= bus.disp_dest_addr;
        end
    end

    // The order counter survives flushes so the trace index never repeats or skips.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            order_count       <= '0;
            bus.mfi_valid     <= 1'b0;
            bus.mfi_order     <= '0;
            bus.mfi_insn      <= '0;
            bus.mfi_src1_addr <= '0;
            bus.mfi_src2_addr <= '0;
            bus.mfi_dest_addr <= '0;
        end else if (retire) begin
            order_count       <= order_count + ORDER_ONE;
            bus.mfi_valid     <= 1'b1;
            bus.mfi_order     <= order_count;
            bus.mfi_insn      <= ent_insn[head_idx];
            bus.mfi_src1_addr <= ent_src1[head_idx];
            bus.mfi_src2_addr <= ent_src2[head_idx];
            bus.mfi_dest_addr <= ent_dest[head_idx];
        end else begin
            bus.mfi_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.err <= 1'b0;
        end else if (cmp_bad) begin
            bus.err <= 1'b1;
        end
    end
endmodule
